vga_sync_generator: RTL and testbench

- Consumes the 25 MHz vgaClk from the clock generator and produces 640x480@60 Hz VGA timing: hsync, vsync, and the pixel coordinate fed to the framebuffer.
- Accepts the returned 8-bit pixel (RRRGGGBB) one cycle later and drives blanked RGB, so data and sync leave the block aligned.
- Sits between the framebuffer read port (synchronous RAM, 1-cycle read latency) and the board VGA connector.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_axis_counter.sv | 49 ++++
 rtl/vga_sync_generator.sv | 99 +++++++++
 tb/tb_vga_sync_generator.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and types for the 640x480@60 Hz sync generator.
package vga_pkg;

    typedef logic [7:0] pixel_t;   // RRRGGGBB
    typedef logic [9:0] coord_t;   // 10-bit pixel/line counter

    // Default 640x480@60 Hz timing (25 MHz pixel clock)
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FRONT  = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BACK   = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FRONT  = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BACK   = 33;
    localparam logic        DEF_SYNC_POL = 1'b0;  // active-low syncs

    localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    // Colour-bar pattern: bar index bits replicated into the R, G and B fields
    function automatic pixel_t bar_colour(logic [2:0] idx);
        return {{3{idx[2]}}, {3{idx[1]}}, {2{idx[0]}}};
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping counter plus active-area and sync-window decode.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned FRONT  = DEF_H_FRONT,
    parameter int unsigned SYNC   = DEF_H_SYNC,
    parameter int unsigned BACK   = DEF_H_BACK
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   enable,
    output coord_t count,
    output logic   last,
    output logic   active,
    output logic   sync_on
);

    localparam int unsigned TOTAL = ACTIVE + FRONT + SYNC + BACK;

    if (TOTAL > 1024) begin : g_total_check
        $error("vga_axis_counter: axis total does not fit a 10-bit counter");
    end

    // Window bounds kept 11 bits wide so an end bound of 1024 does not alias to 0
    localparam coord_t     LAST_CNT   = coord_t'(TOTAL - 1);
    localparam logic [10:0] ACTIVE_END = 11'(ACTIVE);
    localparam logic [10:0] SYNC_START = 11'(ACTIVE + FRONT);
    localparam logic [10:0] SYNC_END   = 11'(ACTIVE + FRONT + SYNC);

    coord_t      count_q;
    logic [10:0] count_ext;

    assign count_ext = {1'b0, count_q};
    assign count     = count_q;
    assign last      = (count_q == LAST_CNT);
    assign active    = (count_ext < ACTIVE_END);
    assign sync_on   = (count_ext >= SYNC_START) && (count_ext < SYNC_END);

    // Counter advances when enabled, wrapping after the last position
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= last ? '0 : count_q + 1'b1;
        end
    end

endmodule

// File: rtl/vga_sync_generator.sv
// VGA sync generator: stage-0 counters issue framebuffer addresses, stage-1 registers
// syncs so they line up with the pixel returned by the 1-cycle-latency framebuffer.
// Optional build macro VGA_TEST_PATTERN_EN replaces pixelIn with 128-pixel colour bars.
module vga_sync_generator
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FRONT  = DEF_H_FRONT,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BACK   = DEF_H_BACK,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FRONT  = DEF_V_FRONT,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BACK   = DEF_V_BACK,
    parameter logic        SYNC_POL = DEF_SYNC_POL
) (
    input  logic   vgaClk,
    input  logic   resetN,
    input  pixel_t pixelIn,
    output coord_t pixelX,
    output coord_t pixelY,
    output logic   addrValid,
    output logic   hsync,
    output logic   vsync,
    output pixel_t rgb,
    output logic   videoOn,
    output logic   frameStart
);

    logic h_last, h_active, h_sync_on;
    logic v_active, v_sync_on;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK)
    ) u_h_axis (
        .clk     (vgaClk),
        .rst_n   (resetN),
        .enable  (1'b1),
        .count   (pixelX),
        .last    (h_last),
        .active  (h_active),
        .sync_on (h_sync_on)
    );

    // Vertical axis steps once per line, on the horizontal wrap
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK)
    ) u_v_axis (
        .clk     (vgaClk),
        .rst_n   (resetN),
        .enable  (h_last),
        .count   (pixelY),
        .last    (),
        .active  (v_active),
        .sync_on (v_sync_on)
    );

    assign addrValid = h_active && v_active;

    // Stage 1: syncs, video-on and frame marker delayed to match framebuffer latency
    always_ff @(posedge vgaClk) begin
        if (!resetN) begin
            hsync      <= ~SYNC_POL;
            vsync      <= ~SYNC_POL;
            videoOn    <= 1'b0;
            frameStart <= 1'b0;
        end else begin
            hsync      <= h_sync_on ? SYNC_POL : ~SYNC_POL;
            vsync      <= v_sync_on ? SYNC_POL : ~SYNC_POL;
            videoOn    <= addrValid;
            frameStart <= (pixelX == '0) && (pixelY == '0);
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar_q;

    // Bar index tracks the address issued last cycle, like a framebuffer read
    always_ff @(posedge vgaClk) begin
        if (!resetN) begin
            bar_q <= '0;
        end else begin
            bar_q <= pixelX[9:7];
        end
    end

    assign rgb = videoOn ? bar_colour(bar_q) : 8'h00;
`else
    // Mux (not AND-mask) so unknown framebuffer data during blanking never reaches rgb
    assign rgb = videoOn ? pixelIn : 8'h00;
`endif

endmodule

// File: tb/tb_vga_sync_generator.sv
// Self-checking bench: a default-timing instance and a shrunken, positive-polarity
// instance are both checked every cycle against an arithmetic position model.
module tb_vga_sync_generator;

    localparam int D_HA = 640, D_HF = 16, D_HS = 96, D_HB = 48;
    localparam int D_VA = 480, D_VF = 10, D_VS = 2, D_VB = 33;
    localparam int S_HA = 40, S_HF = 4, S_HS = 6, S_HB = 5;
    localparam int S_VA = 30, S_VF = 2, S_VS = 2, S_VB = 3;
    localparam int S_FRAME = (S_HA + S_HF + S_HS + S_HB) * (S_VA + S_VF + S_VS + S_VB);
    localparam int D_HT = D_HA + D_HF + D_HS + D_HB;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic       resetN;
    logic [7:0] pix_d, pix_s;

    logic [9:0] px_d, py_d, px_s, py_s;
    logic       av_d, hs_d, vs_d, von_d, fs_d;
    logic       av_s, hs_s, vs_s, von_s, fs_s;
    logic [7:0] rgb_d, rgb_s;

    vga_sync_generator u_dut_default (
        .vgaClk     (clk),
        .resetN     (resetN),
        .pixelIn    (pix_d),
        .pixelX     (px_d),
        .pixelY     (py_d),
        .addrValid  (av_d),
        .hsync      (hs_d),
        .vsync      (vs_d),
        .rgb        (rgb_d),
        .videoOn    (von_d),
        .frameStart (fs_d)
    );

    vga_sync_generator #(
        .H_ACTIVE (S_HA), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
        .V_ACTIVE (S_VA), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB),
        .SYNC_POL (1'b1)
    ) u_dut_small (
        .vgaClk     (clk),
        .resetN     (resetN),
        .pixelIn    (pix_s),
        .pixelX     (px_s),
        .pixelY     (py_s),
        .addrValid  (av_s),
        .hsync      (hs_s),
        .vsync      (vs_s),
        .rgb        (rgb_s),
        .videoOn    (von_s),
        .frameStart (fs_s)
    );

    int total = 0;
    int bad   = 0;
    // p = cycles since the last edge that sampled reset low; p=0 means stage 0 at (0,0)
    int p_d = 0;
    int p_s = 0;
    logic [7:0] seed_d, seed_s;

    logic stats_on = 1'b0;
    int   hs_low_first_line = 0;
    int   hs_fall_1 = 0;
    int   hs_fall_2 = 0;
    logic hs_prev = 1'b1;
    int   fs_cnt = 0;
    int   von_cnt = 0;

    // Framebuffer contents as a function of position
    function automatic logic [7:0] ram(int x, int y, logic [7:0] seed);
        return 8'((x * 5) ^ (y * 3) ^ int'(seed));
    endfunction

    // Framebuffer read data for the address issued one cycle before position p
    function automatic logic [7:0] fb_data(int p, int ha, int ht, int va, int vt,
                                           logic [7:0] seed);
        int x, y;
        if (p == 0) return 8'bx;
        x = (p - 1) % ht;
        y = ((p - 1) / ht) % vt;
        if (x < ha && y < va) return ram(x, y, seed);
        return 8'bx;
    endfunction

    // Expected {pixelX, pixelY, addrValid, hsync, vsync, rgb, videoOn, frameStart}
    function automatic logic [32:0] model(int p, int ha, int hf, int hs, int hb,
                                          int va, int vf, int vs, int vb,
                                          logic pol, logic [7:0] seed);
        int ht, vt, x, y, qx, qy;
        logic av, hsy, vsy, von, fs;
        logic [7:0] c;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        x  = p % ht;
        y  = (p / ht) % vt;
        av = (x < ha) && (y < va);
        if (p == 0) begin
            hsy = ~pol; vsy = ~pol; von = 1'b0; c = 8'h00; fs = 1'b0;
        end else begin
            qx  = (p - 1) % ht;
            qy  = ((p - 1) / ht) % vt;
            hsy = (qx >= ha + hf && qx < ha + hf + hs) ? pol : ~pol;
            vsy = (qy >= va + vf && qy < va + vf + vs) ? pol : ~pol;
            von = (qx < ha) && (qy < va);
            c   = von ? ram(qx, qy, seed) : 8'h00;
            fs  = (qx == 0) && (qy == 0);
        end
        return {10'(x), 10'(y), av, hsy, vsy, c, von, fs};
    endfunction

    task automatic step();
        logic r;
        logic [32:0] exp_d, exp_s, obs_d, obs_s;
        r = resetN;
        @(posedge clk);
        #1;
        p_d = r ? p_d + 1 : 0;
        p_s = r ? p_s + 1 : 0;
        pix_d = fb_data(p_d, D_HA, D_HT, D_VA, D_VA + D_VF + D_VS + D_VB, seed_d);
        pix_s = fb_data(p_s, S_HA, S_HA + S_HF + S_HS + S_HB, S_VA,
                        S_VA + S_VF + S_VS + S_VB, seed_s);
        #1;
        exp_d = model(p_d, D_HA, D_HF, D_HS, D_HB, D_VA, D_VF, D_VS, D_VB, 1'b0, seed_d);
        exp_s = model(p_s, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 1'b1, seed_s);
        obs_d = {px_d, py_d, av_d, hs_d, vs_d, rgb_d, von_d, fs_d};
        obs_s = {px_s, py_s, av_s, hs_s, vs_s, rgb_s, von_s, fs_s};
        total++;
        assert (obs_d === exp_d) else begin
            bad++;
            $error("FAIL outs_default p=%0d observed=%h expected=%h", p_d, obs_d, exp_d);
        end
        total++;
        assert (obs_s === exp_s) else begin
            bad++;
            $error("FAIL outs_small p=%0d observed=%h expected=%h", p_s, obs_s, exp_s);
        end
        if (stats_on) begin
            if (p_d >= 1 && p_d <= D_HT && hs_d === 1'b0) hs_low_first_line++;
            if (hs_prev === 1'b1 && hs_d === 1'b0) begin
                if (hs_fall_1 == 0) hs_fall_1 = p_d;
                else if (hs_fall_2 == 0) hs_fall_2 = p_d;
            end
            if (p_s >= 1 && p_s <= 3 * S_FRAME) begin
                if (fs_s === 1'b1) fs_cnt++;
                if (von_s === 1'b1) von_cnt++;
            end
        end
        hs_prev = hs_d;
    endtask

    initial begin
        int n;
        seed_d = 8'($urandom);
        seed_s = 8'($urandom);
        resetN = 1'b0;
        pix_d  = 8'bx;
        pix_s  = 8'bx;
        repeat (4) step();

        // Phase A: three small frames from a clean release, collecting timing stats
        resetN   = 1'b1;
        stats_on = 1'b1;
        repeat (3 * S_FRAME + 10) step();
        stats_on = 1'b0;

        total++;
        assert (hs_fall_1 === D_HA + D_HF + 1) else begin
            bad++;
            $error("FAIL hsync_first_low observed=%0d expected=%0d", hs_fall_1, D_HA + D_HF + 1);
        end
        total++;
        assert (hs_low_first_line === D_HS) else begin
            bad++;
            $error("FAIL hsync_low_width observed=%0d expected=%0d", hs_low_first_line, D_HS);
        end
        total++;
        assert (hs_fall_2 - hs_fall_1 === D_HT) else begin
            bad++;
            $error("FAIL hsync_period observed=%0d expected=%0d", hs_fall_2 - hs_fall_1, D_HT);
        end
        total++;
        assert (fs_cnt === 3) else begin
            bad++;
            $error("FAIL frame_start_count observed=%0d expected=%0d", fs_cnt, 3);
        end
        total++;
        assert (von_cnt === 3 * S_HA * S_VA) else begin
            bad++;
            $error("FAIL video_on_count observed=%0d expected=%0d", von_cnt, 3 * S_HA * S_VA);
        end

        // Mid-line reset held for 3 cycles once the default instance reaches x=300
        n = 0;
        while ((p_d % D_HT) != 300 && n < 2 * D_HT) begin
            step();
            n++;
        end
        total++;
        assert ((p_d % D_HT) == 300) else begin
            bad++;
            $error("FAIL reach_x300 observed=%0d expected=%0d", p_d % D_HT, 300);
        end
        resetN = 1'b0;
        repeat (3) step();
        resetN = 1'b1;
        repeat (2 * S_FRAME) step();

        // Randomised run lengths, reset pulses and framebuffer contents
        for (int k = 0; k < 4; k++) begin
            seed_d = 8'($urandom);
            seed_s = 8'($urandom);
            repeat ($urandom_range(2000, 10000)) step();
            resetN = 1'b0;
            repeat ($urandom_range(1, 4)) step();
            resetN = 1'b1;
        end
        repeat (200) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
